// File: rtl/alu_md_seq.sv
// alu_md_seq: handshaked RV32I ALU plus RV32M multiply/divide execute unit.
// Optional macro ALU_MD_FAST_MUL_EN: MUL* become single-cycle combinational ops.
module alu_md_seq #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           op,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 busy
);
    localparam int W     = BIT_WIDTH;
    localparam int SH_W  = $clog2(BIT_WIDTH);
    localparam int CNT_W = $clog2(BIT_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIT_WIDTH - 1);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLT    = 5'd2;
    localparam logic [4:0] OP_SLTU   = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_XOR    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [4:0]       opr;
    logic [W:0]       hi;
    logic [W-1:0]     lo;
    logic [W-1:0]     dvs;
    logic             neg;
    logic             div0;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic             a_sgn, b_sgn;
    logic [W-1:0]     a_mag, b_mag;
    logic [W:0]       step_hi;
    logic [W-1:0]     step_lo;
    logic [W:0]       mul_t, rs, diff;
    logic [2*W-1:0]   prod, prod_s;
    logic [W-1:0]     quo_s, rem_s, fin;

    function automatic logic is_div(input logic [4:0] f);
        return (f == OP_DIV) || (f == OP_DIVU) || (f == OP_REM) || (f == OP_REMU);
    endfunction

    function automatic logic is_multi(input logic [4:0] f);
`ifdef ALU_MD_FAST_MUL_EN
        return is_div(f);
`else
        return is_div(f) || (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_MULHU);
`endif
    endfunction

    function automatic logic [W-1:0] alu_1c(input logic [4:0] f, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [SH_W-1:0] sh;
        logic [W-1:0]    r;
`ifdef ALU_MD_FAST_MUL_EN
        logic [2*W-1:0]  xe, ye, p;
`endif
        sh = y[SH_W-1:0];
        r  = '0;
`ifdef ALU_MD_FAST_MUL_EN
        // Sign-extending to 2*W makes one unsigned multiply serve all signedness variants.
        xe = {{W{x[W-1] & ((f == OP_MULH) || (f == OP_MULHSU))}}, x};
        ye = {{W{y[W-1] & (f == OP_MULH)}}, y};
        p  = xe * ye;
`endif
        case (f)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_SLT:  r = {{(W-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: r = {{(W-1){1'b0}}, x < y};
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $signed(x) >>> sh;
`ifdef ALU_MD_FAST_MUL_EN
            OP_MUL:                        r = p[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  r = p[2*W-1:W];
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Handshake: a request transfers when in_valid & in_ready at a rising edge; a result
    // transfers when out_valid & out_ready. A DONE result may retire and be replaced by a
    // new request in the same cycle.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = a[W-1];
                b_sgn = b[W-1];
            end
            OP_MULHSU: a_sgn = a[W-1];
            default: ;
        endcase
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        step_hi = hi;
        step_lo = lo;
        mul_t   = '0;
        rs      = '0;
        diff    = '0;
        if (is_div(opr)) begin
            rs   = {hi[W-1:0], lo[W-1]};
            diff = rs - {1'b0, dvs};
            if (!diff[W]) begin
                step_hi = diff;
                step_lo = {lo[W-2:0], 1'b1};
            end else begin
                step_hi = rs;
                step_lo = {lo[W-2:0], 1'b0};
            end
        end else begin
            mul_t   = lo[0] ? (hi + {1'b0, dvs}) : hi;
            step_hi = {1'b0, mul_t[W:1]};
            step_lo = {mul_t[0], lo[W-1:1]};
        end
    end

    always_comb begin
        prod   = {step_hi[W-1:0], step_lo};
        prod_s = neg ? -prod : prod;
        quo_s  = neg ? -step_lo : step_lo;
        rem_s  = neg ? -step_hi[W-1:0] : step_hi[W-1:0];
        case (opr)
            OP_MUL:                       fin = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              fin = div0 ? '1 : quo_s;
            OP_REM, OP_REMU:              fin = rem_s;
            default:                      fin = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            opr       <= '0;
            hi        <= '0;
            lo        <= '0;
            dvs       <= '0;
            neg       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        opr <= op;
                        if (is_multi(op)) begin
                            state     <= BUSY;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            hi        <= '0;
                            div0      <= (b == '0);
                            // Remainder takes the dividend's sign; everything else the XOR.
                            neg       <= (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
                            if (is_div(op)) begin
                                lo  <= a_mag;
                                dvs <= b_mag;
                            end else begin
                                lo  <= b_mag;
                                dvs <= a_mag;
                            end
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_1c(op, a, b);
                        end
                    end
                end
                BUSY: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= fin;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_seq.sv
// tb_alu_md_seq: directed plus random stimulus against a cycle-level behavioural model.
// Honours ALU_MD_FAST_MUL_EN for the expected multiply latency.
`timescale 1ns/1ps
module tb_alu_md_seq;
    localparam int W = 32;
`ifdef ALU_MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;

    alu_md_seq #(.BIT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           rand_rdy = 0;
    bit           last_acc = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    bit           multi_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [4:0] f);
        if (f >= 5'd14 && f <= 5'd17) return DIV_LAT;
        if (f >= 5'd10 && f <= 5'd13) return MUL_LAT;
        return 1;
    endfunction

    function automatic logic [W-1:0] ref_op(input logic [4:0] f, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        longint       sx, sy, ux, uy;
        logic [63:0]  p;
        int           ix, iy;
        logic [W-1:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = $signed(x);
        iy = $signed(y);
        p  = '0;
        r  = '0;
        case (f)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = (ix < iy) ? 1 : 0;
            5'd3:  r = (x < y) ? 1 : 0;
            5'd4:  r = x & y;
            5'd5:  r = x | y;
            5'd6:  r = x ^ y;
            5'd7:  r = x << y[4:0];
            5'd8:  r = x >> y[4:0];
            5'd9:  r = 32'(ix >>> y[4:0]);
            5'd10: begin p = ux * uy; r = p[31:0]; end
            5'd11: begin p = sx * sy; r = p[63:32]; end
            5'd12: begin p = sx * uy; r = p[63:32]; end
            5'd13: begin p = ux * uy; r = p[63:32]; end
            5'd14: begin
                if (y == 0) r = '1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = 32'(ix / iy);
            end
            5'd15: r = (y == 0) ? '1 : x / y;
            5'd16: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
                else r = 32'(ix % iy);
            end
            5'd17: r = (y == 0) ? x : x % y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit m_valid, m_busy, m_rdy;
        cyc++;
        last_acc = 0;
        if (!rst_n) begin
            exp_q.delete();
            due_q.delete();
            multi_q.delete();
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_result", result, 0);
            chk("rst_in_ready", {31'b0, in_ready}, 1);
        end else begin
            m_valid = (exp_q.size() > 0) && (cyc >= due_q[0]);
            m_busy  = (exp_q.size() > 0) && multi_q[0] && (cyc < due_q[0]);
            m_rdy   = (exp_q.size() == 0) || (m_valid && out_ready);
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            if (m_valid) chk("result", result, exp_q[0]);
            if (m_valid && out_ready) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                void'(multi_q.pop_front());
            end
            if (in_valid && m_rdy) begin
                exp_q.push_back(ref_op(op, a, b));
                due_q.push_back(cyc + lat_of(op));
                multi_q.push_back(lat_of(op) > 1);
                last_acc = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [4:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        in_valid = 1'b1;
        op = f;
        a = x;
        b = y;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        chk("accept_timeout", {31'b0, last_acc}, 1);
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        chk("pin_add", ref_op(5'd0, 32'd5, 32'd7), 32'd12);
        chk("pin_sub", ref_op(5'd1, 32'd3, 32'd5), 32'hFFFF_FFFE);
        chk("pin_sra", ref_op(5'd9, 32'h8000_0000, 32'h24), 32'hF800_0000);
        chk("pin_slt", ref_op(5'd2, 32'hFFFF_FFFF, 32'd1), 32'd1);
        chk("pin_sltu", ref_op(5'd3, 32'hFFFF_FFFF, 32'd1), 32'd0);
        chk("pin_mulh", ref_op(5'd11, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFF);
        chk("pin_mulhu", ref_op(5'd13, 32'hFFFF_FFFF, 32'd2), 32'd1);
        chk("pin_div", ref_op(5'd14, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem", ref_op(5'd16, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_divu0", ref_op(5'd15, 32'd9, 32'd0), 32'hFFFF_FFFF);
        chk("pin_remu0", ref_op(5'd17, 32'd9, 32'd0), 32'd9);
        chk("pin_divovf", ref_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("pin_removf", ref_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        repeat (3) step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        issue(5'd0, 32'd5, 32'd7);
        issue(5'd1, 32'd3, 32'd5);
        issue(5'd9, 32'h8000_0000, 32'h24);
        issue(5'd2, 32'hFFFF_FFFF, 32'd1);
        issue(5'd3, 32'hFFFF_FFFF, 32'd1);
        issue(5'd20, 32'd5, 32'd7);
        issue(5'd11, 32'hFFFF_FFFE, 32'd3);
        issue(5'd13, 32'hFFFF_FFFF, 32'd2);
        issue(5'd14, 32'hFFFF_FFF9, 32'd2);
        issue(5'd16, 32'hFFFF_FFF9, 32'd2);
        issue(5'd15, 32'd9, 32'd0);
        issue(5'd17, 32'd9, 32'd0);
        issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // Consumer stall: result must hold, then a new op is taken the cycle it drains.
        out_ready = 1'b0;
        issue(5'd0, 32'd100, 32'd23);
        repeat (5) step();
        out_ready = 1'b1;
        issue(5'd6, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        wait_idle();

        // Reset during the tenth BUSY cycle of a divide discards it.
        issue(5'd14, 32'd1000, 32'd7);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (40) step();
        issue(5'd0, 32'd1, 32'd1);
        wait_idle();

        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            logic [4:0] f;
            f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            repeat ($urandom_range(0, 2)) step();
            issue(f, pick_val(), pick_val());
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
